range_loader: RTL and testbench

Streams the day-2 puzzle input as ASCII bytes, parses `a-b,c-d,...` into 64-bit start/end pairs, and writes each pair as a 128-bit `{end,start}` word into the solver's range memory. It sits directly upstream of `solver`. `done` releases the solver's reset, and `range_count` tells it how many entries are valid.

---
 rtl/day2_pkg.sv | 37 +++
 rtl/range_loader_if.sv | 27 ++
 rtl/dec_accum.sv | 34 +++
 rtl/range_loader.sv | 169 ++++++++++++++++
 tb/tb_range_loader.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/day2_pkg.sv
// Shared constants, FSM state encoding and byte classification for the range loader.
package day2_pkg;

    localparam int RANGE_W = 64;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [2:0] {
        S_START,
        S_END,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_DASH,
        CLS_COMMA,
        CLS_WS,
        CLS_BAD
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        if (b >= CH_0 && b <= CH_9) return CLS_DIGIT;
        if (b == CH_DASH)           return CLS_DASH;
        if (b == CH_COMMA)          return CLS_COMMA;
        if (b == CH_LF || b == CH_CR) return CLS_WS;
        return CLS_BAD;
    endfunction

endpackage

// File: rtl/range_loader_if.sv
// Byte-stream input and range-memory write bundle between source, loader and solver.
interface range_loader_if
    import day2_pkg::*;
#(
    parameter int ADDR_W = 6
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [2*RANGE_W-1:0]   wr_data;
    logic [ADDR_W:0]        range_count;
    logic                   done;
    logic                   error;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data, range_count, done, error
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, range_count, done, error
    );
endinterface

// File: rtl/dec_accum.sv
// Decimal accumulator: acc <= acc*10 + digit, with a 4-bit headroom overflow flag.
module dec_accum #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [3:0]   digit_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] nxt_o,
    output logic         ovf_o
);

    logic [W-1:0] acc_q;
    logic [W+3:0] acc_d;

    // x10 of a W-bit value plus 9 always fits in W+4 bits, so the top nibble is the overflow
    assign acc_d = {4'b0000, acc_q} * (W+4)'(10) + {{W{1'b0}}, digit_i};
    assign nxt_o = acc_d[W-1:0];
    assign ovf_o = |acc_d[W+3:W];
    assign acc_o = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d[W-1:0];
        end
    end

endmodule

// File: rtl/range_loader.sv
// Parses an ASCII "a-b,c-d,..." stream into {end,start} range records for the solver.
// S_START: start value | S_END: end value | S_EMIT: write bubble | S_DONE / S_ERR: sticky.
module range_loader
    import day2_pkg::*;
#(
    parameter int RANGE_COUNT = 38,
    parameter int ADDR_W      = 6
) (
    input  logic           clk,
    input  logic           rst,
    range_loader_if.slave  bus
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(RANGE_COUNT);

    state_e                 state_q;
    logic                   seen_q;
    logic                   fin_q;
    logic [RANGE_W-1:0]     start_q;
    logic [ADDR_W:0]        count_q;
    logic                   wr_en_q;
    logic [ADDR_W-1:0]      wr_addr_q;
    logic [2*RANGE_W-1:0]   wr_data_q;
    logic                   done_q;
    logic                   error_q;

    logic                   accept;
    byte_class_e            cls;
    logic [RANGE_W-1:0]     acc_q;
    logic [RANGE_W-1:0]     acc_nxt;
    logic                   acc_ovf;
    logic                   acc_en;
    logic                   acc_clr;
    logic                   commit;
    logic                   fail;
    logic                   finish;
    logic [RANGE_W-1:0]     end_val;

    assign bus.in_ready    = (state_q == S_START) || (state_q == S_END);
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.range_count = count_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign cls     = classify(bus.in_data);
    assign acc_en  = accept && (cls == CLS_DIGIT);
    assign acc_clr = accept && (cls == CLS_DASH || cls == CLS_COMMA);

    dec_accum #(.W(RANGE_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .digit_i (bus.in_data[3:0]),
        .acc_o   (acc_q),
        .nxt_o   (acc_nxt),
        .ovf_o   (acc_ovf)
    );

    always_comb begin
        commit  = 1'b0;
        fail    = 1'b0;
        finish  = 1'b0;
        end_val = acc_q;
        if (accept) begin
            case (state_q)
                S_START: begin
                    case (cls)
                        CLS_DIGIT: fail = acc_ovf || bus.in_last;
                        CLS_DASH:  fail = !seen_q || bus.in_last;
                        CLS_WS: begin
                            if (bus.in_last) begin
                                fail   = seen_q;
                                finish = !seen_q;
                            end
                        end
                        default:   fail = 1'b1;
                    endcase
                end
                S_END: begin
                    case (cls)
                        CLS_DIGIT: begin
                            if (acc_ovf) begin
                                fail = 1'b1;
                            end else if (bus.in_last) begin
                                commit  = 1'b1;
                                end_val = acc_nxt;
                            end
                        end
                        CLS_COMMA: begin
                            fail   = !seen_q;
                            commit = seen_q;
                        end
                        CLS_WS: begin
                            if (bus.in_last) begin
                                fail   = !seen_q;
                                commit = seen_q;
                            end
                        end
                        default:   fail = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
        // Inverted or overflowing records turn into an error in place of the emit
        if (commit && (start_q > end_val || count_q == CAP)) begin
            commit = 1'b0;
            fail   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_START;
            seen_q    <= 1'b0;
            fin_q     <= 1'b0;
            start_q   <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_START, S_END: begin
                    if (accept) begin
                        if (fail) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (commit) begin
                            state_q   <= S_EMIT;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= count_q[ADDR_W-1:0];
                            wr_data_q <= {end_val, start_q};
                            count_q   <= count_q + {{ADDR_W{1'b0}}, 1'b1};
                            seen_q    <= 1'b0;
                            fin_q     <= bus.in_last;
                        end else if (finish) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (cls == CLS_DIGIT) begin
                            seen_q <= 1'b1;
                        end else if (cls == CLS_DASH) begin
                            start_q <= acc_q;
                            seen_q  <= 1'b0;
                            state_q <= S_END;
                        end
                    end
                end
                S_EMIT: begin
                    wr_en_q <= 1'b0;
                    if (fin_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_START;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_range_loader.sv
// Randomized and directed stimulus for range_loader, checked against a string-level parse model.
module tb_range_loader;
    import day2_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    bit         sel;
    int         cyc = 0;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    range_loader_if #(.ADDR_W(6)) b0 ();
    range_loader_if #(.ADDR_W(1)) b1 ();

    assign b0.in_valid = in_valid;
    assign b0.in_data  = in_data;
    assign b0.in_last  = in_last;
    assign b1.in_valid = in_valid;
    assign b1.in_data  = in_data;
    assign b1.in_last  = in_last;

    range_loader #(.RANGE_COUNT(38), .ADDR_W(6)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    range_loader #(.RANGE_COUNT(2),  .ADDR_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic       s_rdy, s_done, s_err;
    logic [6:0] s_cnt;
    assign s_rdy  = sel ? b1.in_ready : b0.in_ready;
    assign s_done = sel ? b1.done     : b0.done;
    assign s_err  = sel ? b1.error    : b0.error;
    assign s_cnt  = sel ? 7'(b1.range_count) : b0.range_count;

    int            wa0[$], wa1[$], wc0[$], wc1[$];
    logic [127:0]  wd0[$], wd1[$];
    int            done_cyc, err_cyc;
    int            acc_cyc[512];

    always @(negedge clk) begin
        if (b0.wr_en) begin
            wa0.push_back(int'(b0.wr_addr));
            wd0.push_back(b0.wr_data);
            wc0.push_back(cyc);
        end
        if (b1.wr_en) begin
            wa1.push_back(int'(b1.wr_addr));
            wd1.push_back(b1.wr_data);
            wc1.push_back(cyc);
        end
        if (s_done && done_cyc < 0) done_cyc = cyc;
        if (s_err && err_cyc < 0) err_cyc = cyc;
    end

    logic [127:0] exp_q[$];
    int           exp_cnt;
    bit           exp_done, exp_err;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        wa0.delete(); wd0.delete(); wc0.delete();
        wa1.delete(); wd1.delete(); wc1.delete();
        done_cyc = -1;
        err_cyc  = -1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Drives one byte per accepted handshake; stops early once the DUT is finished or failed.
    task automatic send(input string s, input bit mark_last, input bit gaps);
        bit ok;
        bit stop;
        stop = 1'b0;
        for (int i = 0; i < s.len() && !stop; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #2;
                end
            end
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = mark_last && (i == s.len() - 1);
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok && !stop; t++) begin
                @(negedge clk);
                if (s_rdy) ok = 1'b1;
                else if (s_done || s_err) stop = 1'b1;
            end
            if (!ok) begin
                if (!stop) chk("hs_ready", s_rdy, 1);
                stop = 1'b1;
            end else begin
                acc_cyc[i] = cyc;
                @(posedge clk);
                #2;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic try_emit(input logic [63:0] a, input logic [63:0] e, input int cap,
                            output bit bad);
        bad = (a > e) || (exp_cnt == cap);
        if (!bad) begin
            exp_q.push_back({e, a});
            exp_cnt++;
        end
    endtask

    // Plain-arithmetic parse of the whole string into the expected record list and outcome.
    task automatic model(input string s, input bit mark_last, input int cap);
        logic [67:0] acc;
        logic [63:0] st;
        logic [7:0]  c;
        bit ph, seen, bad, last;
        exp_q.delete();
        exp_cnt  = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        acc = '0; st = '0; ph = 1'b0; seen = 1'b0; bad = 1'b0;
        for (int i = 0; i < s.len() && !bad; i++) begin
            c    = s[i];
            last = mark_last && (i == s.len() - 1);
            if (c >= CH_0 && c <= CH_9) begin
                acc  = acc * 68'd10 + 68'(c - CH_0);
                seen = 1'b1;
                if (acc > 68'hFFFF_FFFF_FFFF_FFFF) bad = 1'b1;
            end else if (c == CH_DASH) begin
                if (!ph && seen) begin
                    st = acc[63:0]; acc = '0; seen = 1'b0; ph = 1'b1;
                end else bad = 1'b1;
            end else if (c == CH_COMMA) begin
                if (ph && seen) begin
                    try_emit(st, acc[63:0], cap, bad);
                    acc = '0; seen = 1'b0; ph = 1'b0;
                end else bad = 1'b1;
            end else if (c != CH_LF && c != CH_CR) begin
                bad = 1'b1;
            end
            if (!bad && last) begin
                if (ph && seen) try_emit(st, acc[63:0], cap, bad);
                else if (ph || seen) bad = 1'b1;
                if (!bad) exp_done = 1'b1;
            end
        end
        exp_err = bad;
    endtask

    task automatic compare(input string tag);
        int nw;
        nw = sel ? wd1.size() : wd0.size();
        chk({tag, ":done"},  s_done, exp_done);
        chk({tag, ":error"}, s_err, exp_err);
        chk({tag, ":count"}, s_cnt, exp_cnt);
        chk({tag, ":nwr"},   nw, exp_q.size());
        for (int i = 0; i < nw && i < exp_q.size(); i++) begin
            chk({tag, ":addr"}, sel ? wa1[i] : wa0[i], i);
            chk({tag, ":data"}, sel ? wd1[i] : wd0[i], exp_q[i]);
        end
        if (exp_done || exp_err) chk({tag, ":rdy_low"}, s_rdy, 0);
    endtask

    task automatic run(input string tag, input string s, input bit mark_last,
                       input bit sel_v, input bit gaps);
        sel = sel_v;
        do_reset();
        model(s, mark_last, sel_v ? 2 : 38);
        send(s, mark_last, gaps);
        repeat (4) @(posedge clk);
        #2;
        compare(tag);
    endtask

    function automatic string rnd_num(input bit big);
        logic [63:0] v;
        v = big ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 999));
        return $sformatf("%0d", v);
    endfunction

    function automatic string rnd_ws();
        case ($urandom_range(0, 7))
            0:       return "\n";
            1:       return "\r";
            default: return "";
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        string s, a, b;
        bit    big;
        int    nrec, k;

        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; sel = 1'b0;
        do_reset();
        chk("rst:wr_en", b0.wr_en, 0);
        chk("rst:wr_addr", b0.wr_addr, 0);
        chk("rst:wr_data", b0.wr_data, 0);
        chk("rst:count", b0.range_count, 0);
        chk("rst:done", b0.done, 0);
        chk("rst:error", b0.error, 0);

        run("basic", "11-22,95-115\n", 1, 0, 0);
        chk("basic:lit1", wd0.size() > 1 ? wd0[1] : '0, {64'd115, 64'd95});

        run("single", "998-1012", 1, 0, 0);
        chk("single:wr_lat", wc0.size() > 0 ? wc0[0] : -1, acc_cyc[7] + 1);
        chk("single:done_lat", done_cyc, acc_cyc[7] + 2);

        run("inv", "5-3,", 0, 0, 0);
        chk("inv:err_lat", err_cyc, acc_cyc[3] + 1);

        run("ovf", "18446744073709551616-1", 1, 0, 0);
        chk("ovf:err_lat", err_cyc, acc_cyc[19] + 1);

        run("max", "18446744073709551615-18446744073709551615", 1, 0, 0);
        run("empty_ws", "\n", 1, 0, 0);
        run("cap", "1-2,3-4,5-6", 1, 1, 0);

        sel = 1'b0;
        do_reset();
        send("12-3", 0, 0);
        do_reset();
        model("7-9", 1, 38);
        send("7-9", 1, 0);
        repeat (4) @(posedge clk);
        #2;
        compare("rst_mid");

        for (int it = 0; it < 40; it++) begin
            s    = "";
            big  = $urandom_range(0, 1);
            nrec = $urandom_range(1, 4);
            for (int r = 0; r < nrec; r++) begin
                a = rnd_num(big && $urandom_range(0, 1));
                b = rnd_num(big && $urandom_range(0, 1));
                if (r > 0) s = {s, ","};
                s = {s, rnd_ws(), a, "-", rnd_ws(), b, rnd_ws()};
            end
            case ($urandom_range(0, 4))
                1: s = {s, ","};
                2: s = {s, "\n"};
                3: begin
                    k = $urandom_range(1, s.len() - 1);
                    s = {s.substr(0, k - 1), ($urandom_range(0, 1) ? "x" : "-"), s.substr(k, s.len() - 1)};
                end
                default: ;
            endcase
            run($sformatf("rnd%0d", it), s, 1, it[0], $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
